// File: rtl/eth_tx_scheduler.sv
// Round-robin owner selection and frame sequencing for one shared Ethernet transmitter.
// Tracks each frame through tx_active, aborts hung frames and holds the inter-frame gap.
module eth_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 16,
  parameter int FRAME_TIMEOUT = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       tx_active,
  output logic                       start_tx,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic                       busy
);
  localparam int IDW   = $clog2(NUM_REQ);
  localparam int MAX_A = (FRAME_TIMEOUT > IFG_CYCLES) ? FRAME_TIMEOUT : IFG_CYCLES;
  localparam int MAX_T = (MAX_A > START_TIMEOUT) ? MAX_A : START_TIMEOUT;
  localparam int CW    = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] ST_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FR_LAST  = CW'(FRAME_TIMEOUT - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, START, WAIT_ACT, ACTIVE, IFG} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                 start_tx_q, start_tx_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 win_vld;
  logic [IDW-1:0]       win_id;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int step);
    int s;
    s = int'(p) + step;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Walk from the farthest candidate back to ptr+1 so the nearest set request is left standing.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[rr_idx(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_id  = rr_idx(ptr_q, i);
      end
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    err_d      = 1'b0;
    start_tx_d = (state_q == START);
    case (state_q)
      IDLE: begin
        if (enable && (|req)) begin
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
          grant_id_d = win_id;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        cnt_d = cnt_inc;
        if (tx_active) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else if (cnt_q == ST_LAST) begin
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = grant_id_q;
          cnt_d   = '0;
          state_d = IFG;
        end
      end
      ACTIVE: begin
        cnt_d = cnt_inc;
        if (!tx_active || (cnt_q == FR_LAST)) begin
          ack_d   = tx_active ? '0 : grant_q;
          err_d   = tx_active;
          grant_d = '0;
          ptr_d   = grant_id_q;
          cnt_d   = '0;
          state_d = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_inc;
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= IDW'(NUM_REQ - 1);
      cnt_q      <= '0;
      start_tx_q <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      start_tx_q <= start_tx_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign start_tx = start_tx_q;
  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed bench for eth_tx_scheduler: latency, fairness, both timeouts, enable/req changes, reset.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_eth_tx_scheduler;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] req;
  logic         tx_active;
  logic         start_tx;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic [N-1:0] ack;
  logic         err;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  eth_tx_scheduler #(.NUM_REQ(N), .IFG_CYCLES(12), .START_TIMEOUT(16), .FRAME_TIMEOUT(2048)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .tx_active(tx_active),
    .start_tx(start_tx), .grant(grant), .grant_id(grant_id), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; req = '0; tx_active = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Advances until start_tx is seen; n = cycles advanced, n = -1 if the bound expired.
  task automatic wait_start(input int max, output int n);
    n = 0;
    while (!start_tx && n < max) begin cyc(); n++; end
    if (!start_tx) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({start_tx, grant, grant_id, ack, err, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got st=%0b g=%0h id=%0d ack=%0h err=%0b busy=%0b expected all 0",
               start_tx, grant, grant_id, ack, err, busy);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    enable = 1'b1; req = 4'b0001;
    cyc();
    vectors++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || start_tx !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got g=%0h id=%0d st=%0b busy=%0b expected g=1 id=0 st=0 busy=1",
               grant, grant_id, start_tx, busy);
    end
    cyc();
    vectors++;
    if (start_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_start: got start_tx=%0b expected 1", start_tx);
    end
    cyc(); cyc();
    tx_active = 1'b1;
    repeat (72) cyc();
    tx_active = 1'b0;
    vectors++;
    if (ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_early_ack: got ack=%0h expected 0", ack);
    end
    cyc();
    vectors++;
    if (ack !== 4'b0001 || err !== 1'b0 || grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_ack: got ack=%0h err=%0b g=%0h expected ack=1 err=0 g=0", ack, err, grant);
    end
    req = '0;
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    vectors++;
    if (n !== 12) begin
      miscompares++;
      $display("FAIL single_ifg: got busy low %0d cycles after ack expected 12", n);
    end
  endtask

  task automatic test_fairness();
    int n;
    logic [N-1:0] exp_g;
    do_reset();
    enable = 1'b1; req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      exp_g = 4'b0001 << (f % 4);
      wait_start(40, n);
      if (f > 0) begin
        vectors++;
        if (n !== 14) begin
          miscompares++;
          $display("FAIL fair_gap%0d: got %0d cycles ack->start_tx expected 14", f, n);
        end
      end
      vectors++;
      if (grant !== exp_g || grant_id !== 2'(f % 4)) begin
        miscompares++;
        $display("FAIL fair_grant%0d: got g=%0h id=%0d expected g=%0h id=%0d", f, grant, grant_id, exp_g, f % 4);
      end
      cyc(); cyc();
      tx_active = 1'b1;
      repeat (5) cyc();
      tx_active = 1'b0;
      cyc();
      vectors++;
      if (ack !== exp_g) begin
        miscompares++;
        $display("FAIL fair_ack%0d: got ack=%0h expected %0h", f, ack, exp_g);
      end
    end
    req = '0;
    repeat (14) cyc();
  endtask

  task automatic test_start_timeout();
    int n;
    logic ack_seen;
    do_reset();
    enable = 1'b1; req = 4'b0100;
    wait_start(10, n);
    vectors++;
    if (n !== 2 || grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL sto_start: got latency=%0d g=%0h expected 2 g=4", n, grant);
    end
    n = 0; ack_seen = 1'b0;
    while (!err && n < 40) begin cyc(); n++; ack_seen |= (|ack); end
    vectors++;
    if (n !== 16 || ack_seen !== 1'b0 || grant !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sto_err: got delay=%0d ack_seen=%0b g=%0h busy=%0b expected 16 0 0 1",
               n, ack_seen, grant, busy);
    end
    req = 4'b0101;
    n = 0;
    while (grant === 4'b0000 && n < 40) begin cyc(); n++; end
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL sto_next_rr: got g=%0h expected 1", grant);
    end
  endtask

  task automatic test_frame_timeout();
    int n;
    logic ack_seen;
    logic bad;
    do_reset();
    enable = 1'b1; req = 4'b0001;
    wait_start(10, n);
    cyc(); cyc();
    tx_active = 1'b1;
    n = 0; ack_seen = 1'b0;
    while (!err && n < 2100) begin cyc(); n++; ack_seen |= (|ack); end
    // err shows FRAME_TIMEOUT cycles after the edge that first sampled tx_active.
    vectors++;
    if (n !== 2049 || ack_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL fto_err: got delay=%0d ack_seen=%0b expected 2049 0", n, ack_seen);
    end
    req = '0;
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    vectors++;
    if (n !== 12) begin
      miscompares++;
      $display("FAIL fto_idle: got busy low %0d cycles after err expected 12", n);
    end
    bad = 1'b0;
    repeat (939) begin cyc(); bad |= busy | err | (|ack) | start_tx; end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL fto_quiet: got activity=%0b with tx_active stuck high expected 0", bad);
    end
    tx_active = 1'b0;
  endtask

  task automatic test_enable_req();
    int n;
    logic bad;
    do_reset();
    enable = 1'b0; req = 4'b0010;
    bad = 1'b0;
    repeat (10) begin cyc(); bad |= busy | (|grant); end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL en_block: got grant activity=%0b while disabled expected 0", bad);
    end
    enable = 1'b1;
    cyc();
    vectors++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL en_grant: got g=%0h id=%0d expected g=2 id=1", grant, grant_id);
    end
    wait_start(10, n);
    enable = 1'b0;
    cyc(); cyc();
    tx_active = 1'b1;
    cyc();
    req = '0;
    bad = 1'b0;
    repeat (10) begin cyc(); bad |= (grant !== 4'b0010); end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL en_grant_hold: got grant changed=%0b mid-frame expected 0", bad);
    end
    tx_active = 1'b0;
    cyc();
    vectors++;
    if (ack !== 4'b0010 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL en_ack: got ack=%0h err=%0b expected ack=2 err=0", ack, err);
    end
    req = 4'b0010;
    repeat (20) cyc();
    vectors++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL en_no_regrant: got busy=%0b g=%0h expected 0 0", busy, grant);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    enable = 1'b1; req = 4'b0010;
    wait_start(10, n);
    cyc(); cyc();
    tx_active = 1'b1;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; tx_active = 1'b0; req = 4'b1000;
    vectors++;
    if ({start_tx, grant, grant_id, ack, err, busy} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got st=%0b g=%0h id=%0d ack=%0h err=%0b busy=%0b expected all 0",
               start_tx, grant, grant_id, ack, err, busy);
    end
    cyc();
    vectors++;
    if (ack !== 4'b0000 || err !== 1'b0 || grant !== 4'b1000 || grant_id !== 2'd3) begin
      miscompares++;
      $display("FAIL rst_mid_regrant: got ack=%0h err=%0b g=%0h id=%0d expected ack=0 err=0 g=8 id=3",
               ack, err, grant, grant_id);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req = '0; tx_active = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_start_timeout();
    test_frame_timeout();
    test_enable_req();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
